// File: rtl/vga_frame_monitor_if.sv
// VGA output bus as produced by top_vga: active syncs plus 4-bit-per-channel colour.
// The master modport drives the bus; the slave modport observes it.
interface vga_frame_monitor_if;
  logic       hs;
  logic       vs;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;

  modport master (output hs, vs, r, g, b);
  modport slave  (input  hs, vs, r, g, b);
endinterface

// File: rtl/vga_frame_monitor.sv
// Passive VGA timing checker: measures line/frame length and sync widths, keeps a
// per-frame 24-bit pixel checksum and reports sticky errors plus a lock indication.
module vga_frame_monitor #(
  parameter int H_TOTAL     = 1344,
  parameter int H_SYNC_W    = 136,
  parameter int V_TOTAL     = 806,
  parameter int V_SYNC_W    = 6,
  parameter bit SYNC_POL    = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_frame_monitor_if.slave  i_vga,
  input  logic                i_clr_err,
  output logic                o_locked,
  output logic                o_frame_done,
  output logic [23:0]         o_frame_sum,
  output logic [15:0]         o_frame_cnt,
  output logic                o_err_hlen,
  output logic                o_err_hsync,
  output logic                o_err_vlen,
  output logic                o_err_vsync
);

  localparam int HW = $clog2(2 * H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1) + 1;
  localparam int LW = $clog2(LOCK_FRAMES + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_TMO  = HW'(2 * H_TOTAL);
  localparam logic [HW-1:0] H_SW   = HW'(H_SYNC_W);
  localparam logic [VW-1:0] V_TOT  = VW'(V_TOTAL);
  localparam logic [19:0]   V_SW   = 20'(V_SYNC_W * H_TOTAL);
  localparam logic [LW-1:0] LOCK_N = LW'(LOCK_FRAMES);

  logic          r_s1_hs, r_s1_vs, r_s2_hs, r_s2_vs;
  logic [11:0]   r_s1_rgb;
  logic [HW-1:0] r_hcnt, r_hpw;
  logic          r_h_armed, r_v_armed;
  logic [VW-1:0] r_vline;
  logic [19:0]   r_vpw;
  logic [23:0]   r_acc, r_frame_sum;
  logic [15:0]   r_frame_cnt;
  logic          r_frame_done, r_frame_err;
  logic [LW-1:0] r_clean_cnt;
  logic          r_err_hlen, r_err_hsync, r_err_vlen, r_err_vsync;

  logic          w_hs_s1, w_hs_s2, w_vs_s1, w_vs_s2;
  logic          w_hs_lead, w_hs_trail, w_vs_lead, w_vs_trail;
  logic          w_h_timeout, w_frame_end;
  logic          w_hlen_bad, w_hsync_bad, w_vlen_bad, w_vsync_bad, w_any_err;
  logic [VW-1:0] w_vline_now;
  logic [23:0]   w_pixel;

  // Sync registers reset to the deasserted level so reset release is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_hs  <= ~SYNC_POL;
      r_s1_vs  <= ~SYNC_POL;
      r_s2_hs  <= ~SYNC_POL;
      r_s2_vs  <= ~SYNC_POL;
      r_s1_rgb <= '0;
    end else begin
      r_s1_hs  <= i_vga.hs;
      r_s1_vs  <= i_vga.vs;
      r_s2_hs  <= r_s1_hs;
      r_s2_vs  <= r_s1_vs;
      r_s1_rgb <= {i_vga.r, i_vga.g, i_vga.b};
    end
  end

  assign w_hs_s1    = (r_s1_hs == SYNC_POL);
  assign w_hs_s2    = (r_s2_hs == SYNC_POL);
  assign w_vs_s1    = (r_s1_vs == SYNC_POL);
  assign w_vs_s2    = (r_s2_vs == SYNC_POL);
  assign w_hs_lead  = w_hs_s1 & ~w_hs_s2;
  assign w_hs_trail = w_hs_s2 & ~w_hs_s1;
  assign w_vs_lead  = w_vs_s1 & ~w_vs_s2;
  assign w_vs_trail = w_vs_s2 & ~w_vs_s1;

  // The line count seen by a vs edge includes an hs edge landing in the same cycle.
  assign w_vline_now = r_vline + VW'(w_hs_lead);
  assign w_h_timeout = r_h_armed & ~w_hs_lead & (r_hcnt == H_TMO);
  assign w_hlen_bad  = (w_hs_lead & r_h_armed & (r_hcnt != H_LAST)) | w_h_timeout;
  assign w_hsync_bad = w_hs_trail & r_h_armed & (r_hpw != H_SW);
  assign w_vlen_bad  = w_vs_lead & r_v_armed & (w_vline_now != V_TOT);
  assign w_vsync_bad = w_vs_trail & r_v_armed & (r_vpw != V_SW);
  assign w_any_err   = w_hlen_bad | w_hsync_bad | w_vlen_bad | w_vsync_bad;
  assign w_frame_end = w_vs_lead & r_v_armed;
  assign w_pixel     = {12'h000, r_s1_rgb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt    <= '0;
      r_hpw     <= '0;
      r_h_armed <= 1'b0;
    end else begin
      if (w_hs_lead)
        r_hcnt <= '0;
      else if (r_hcnt != H_TMO)
        r_hcnt <= r_hcnt + 1'b1;
      if (w_hs_lead)
        r_h_armed <= 1'b1;
      else if (w_h_timeout)
        r_h_armed <= 1'b0;
      if (w_hs_lead)
        r_hpw <= HW'(1);
      else if (w_hs_s1 && r_hpw != H_TMO)
        r_hpw <= r_hpw + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vline   <= '0;
      r_vpw     <= '0;
      r_v_armed <= 1'b0;
    end else begin
      if (w_vs_lead)
        r_vline <= '0;
      else if (w_hs_lead && r_vline != '1)
        r_vline <= r_vline + 1'b1;
      if (w_vs_lead)
        r_vpw <= 20'd1;
      else if (w_vs_s1 && r_vpw != '1)
        r_vpw <= r_vpw + 1'b1;
      if (w_vs_lead)
        r_v_armed <= 1'b1;
    end
  end

  // The pixel sampled alongside a vs edge is the first pixel of the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_frame_sum  <= '0;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_vs_lead)
        r_acc <= w_pixel;
      else
        r_acc <= r_acc + w_pixel;
      if (w_frame_end) begin
        r_frame_sum <= r_acc;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // A freshly detected error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_hlen  <= 1'b0;
      r_err_hsync <= 1'b0;
      r_err_vlen  <= 1'b0;
      r_err_vsync <= 1'b0;
      r_frame_err <= 1'b0;
      r_clean_cnt <= '0;
    end else begin
      r_err_hlen  <= (r_err_hlen  & ~i_clr_err) | w_hlen_bad;
      r_err_hsync <= (r_err_hsync & ~i_clr_err) | w_hsync_bad;
      r_err_vlen  <= (r_err_vlen  & ~i_clr_err) | w_vlen_bad;
      r_err_vsync <= (r_err_vsync & ~i_clr_err) | w_vsync_bad;
      if (w_vs_lead)
        r_frame_err <= 1'b0;
      else if (w_any_err)
        r_frame_err <= 1'b1;
      if (w_any_err)
        r_clean_cnt <= '0;
      else if (w_frame_end && !r_frame_err && r_clean_cnt != LOCK_N)
        r_clean_cnt <= r_clean_cnt + 1'b1;
    end
  end

  assign o_locked     = (r_clean_cnt == LOCK_N);
  assign o_frame_done = r_frame_done;
  assign o_frame_sum  = r_frame_sum;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_err_hlen   = r_err_hlen;
  assign o_err_hsync  = r_err_hsync;
  assign o_err_vlen   = r_err_vlen;
  assign o_err_vsync  = r_err_vsync;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor with reduced timing (16 clk lines, 10-line frames).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_vga_frame_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_clr_err = 1'b0;
  logic        o_locked, o_frame_done;
  logic [23:0] o_frame_sum;
  logic [15:0] o_frame_cnt;
  logic        o_err_hlen, o_err_hsync, o_err_vlen, o_err_vsync;

  int compared   = 0;
  int mismatched = 0;
  int cycleCount = 0;
  int doneCount  = 0;
  int lastDone   = 0;
  int prevDone   = 0;

  vga_frame_monitor_if vgaBus ();

  vga_frame_monitor #(
    .H_TOTAL(16), .H_SYNC_W(2), .V_TOTAL(10), .V_SYNC_W(1),
    .SYNC_POL(1'b1), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_vga(vgaBus), .i_clr_err(i_clr_err),
    .o_locked(o_locked), .o_frame_done(o_frame_done), .o_frame_sum(o_frame_sum),
    .o_frame_cnt(o_frame_cnt), .o_err_hlen(o_err_hlen), .o_err_hsync(o_err_hsync),
    .o_err_vlen(o_err_vlen), .o_err_vsync(o_err_vsync)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  always @(negedge clk) begin
    if (o_frame_done === 1'b1) begin
      doneCount++;
      prevDone = lastDone;
      lastDone = cycleCount;
    end
  end

  task automatic applyStimulus(input logic hs, input logic vs, input logic [11:0] rgb,
                               input logic clr);
    vgaBus.hs = hs;
    vgaBus.vs = vs;
    {vgaBus.r, vgaBus.g, vgaBus.b} = rgb;
    i_clr_err = clr;
    @(negedge clk);
  endtask

  task automatic driveLine(input int len, input int hsW, input logic vs,
                           input logic [11:0] rgb, input int clrAt);
    for (int i = 0; i < len; i++)
      applyStimulus(i < hsW, vs, rgb, i == clrAt);
  endtask

  task automatic driveFrame(input int nLines, input int vsLines, input logic [11:0] rgb,
                            input int clrLine);
    for (int l = 0; l < nLines; l++)
      driveLine(16, 2, l < vsLines, rgb, (l == clrLine) ? 5 : -1);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    vgaBus.hs = 1'b0;
    vgaBus.vs = 1'b0;
    vgaBus.r = 4'h0;
    vgaBus.g = 4'h0;
    vgaBus.b = 4'h0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_locked", o_locked, 0);
    checkOutput("reset_done", o_frame_done, 0);
    checkOutput("reset_sum", o_frame_sum, 0);
    checkOutput("reset_cnt", o_frame_cnt, 0);
    checkOutput("reset_errs", {o_err_hlen, o_err_hsync, o_err_vlen, o_err_vsync}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);

    $display("[TB] ideal timing");
    driveFrame(10, 1, 12'h001, -1);
    driveFrame(10, 1, 12'h001, -1);
    checkOutput("t1_done_after_f2", doneCount, 1);
    checkOutput("t1_unlocked_after_1_done", o_locked, 0);
    driveFrame(10, 1, 12'h001, -1);
    checkOutput("t1_done_after_f3", doneCount, 2);
    checkOutput("t1_done_interval", lastDone - prevDone, 160);
    checkOutput("t1_locked", o_locked, 1);
    checkOutput("t1_cnt", o_frame_cnt, 2);
    checkOutput("t1_sum", o_frame_sum, 24'h0000A0);
    checkOutput("t1_errs", {o_err_hlen, o_err_hsync, o_err_vlen, o_err_vsync}, 0);

    $display("[TB] 17-clock line");
    for (int l = 0; l < 3; l++) driveLine(16, 2, l == 0, 12'h001, -1);
    driveLine(17, 2, 1'b0, 12'h001, -1);
    applyStimulus(1'b1, 1'b0, 12'h001, 1'b0);
    checkOutput("t3_hlen_not_yet", o_err_hlen, 0);
    checkOutput("t3_locked_before", o_locked, 1);
    applyStimulus(1'b1, 1'b0, 12'h001, 1'b0);
    checkOutput("t3_hlen_set", o_err_hlen, 1);
    checkOutput("t3_locked_drop", o_locked, 0);
    checkOutput("t3_other_errs", {o_err_hsync, o_err_vlen, o_err_vsync}, 0);
    driveLine(14, 0, 1'b0, 12'h001, -1);
    for (int l = 5; l < 10; l++) driveLine(16, 2, 1'b0, 12'h001, -1);
    driveFrame(10, 1, 12'h001, 2);
    checkOutput("t3_long_frame_sum", o_frame_sum, 24'h0000A1);
    checkOutput("t3_cleared", o_err_hlen, 0);
    checkOutput("t3_unlocked_f5", o_locked, 0);
    driveFrame(10, 1, 12'h001, -1);
    checkOutput("t3_sum_f5", o_frame_sum, 24'h0000A0);
    checkOutput("t3_unlocked_f6", o_locked, 0);
    driveFrame(10, 1, 12'h001, -1);
    checkOutput("t3_relocked", o_locked, 1);
    checkOutput("t3_cnt", o_frame_cnt, 6);

    $display("[TB] sync width and frame length faults");
    for (int l = 0; l < 10; l++) driveLine(16, (l == 5) ? 3 : 2, l == 0, 12'h001, -1);
    checkOutput("t4_hsync", o_err_hsync, 1);
    checkOutput("t4_hsync_only", {o_err_hlen, o_err_vlen, o_err_vsync}, 0);
    checkOutput("t4_unlocked", o_locked, 0);
    driveFrame(11, 1, 12'h001, 1);
    checkOutput("t4_hsync_cleared", o_err_hsync, 0);
    checkOutput("t4_vlen_not_yet", o_err_vlen, 0);
    driveFrame(10, 2, 12'h001, -1);
    checkOutput("t4_vlen", o_err_vlen, 1);
    checkOutput("t4_vsync", o_err_vsync, 1);
    checkOutput("t4_h_errs", {o_err_hlen, o_err_hsync}, 0);
    checkOutput("t4_sum_11_lines", o_frame_sum, 24'h0000B0);

    $display("[TB] hs timeout with simultaneous clear");
    driveLine(16, 2, 1'b1, 12'h001, 5);
    checkOutput("t5_all_cleared", {o_err_hlen, o_err_hsync, o_err_vlen, o_err_vsync}, 0);
    driveLine(34, 2, 1'b0, 12'h001, -1);
    checkOutput("t5_timeout_not_yet", o_err_hlen, 0);
    applyStimulus(1'b0, 1'b0, 12'h001, 1'b1);
    checkOutput("t5_timeout_beats_clear", o_err_hlen, 1);
    driveLine(13, 0, 1'b0, 12'h001, -1);
    for (int l = 2; l < 10; l++) driveLine(16, 2, 1'b0, 12'h001, -1);
    checkOutput("t5_hlen_sticky", o_err_hlen, 1);
    checkOutput("t5_other_errs", {o_err_hsync, o_err_vlen, o_err_vsync}, 0);

    $display("[TB] reset mid-frame");
    for (int l = 0; l < 3; l++) driveLine(16, 2, l == 0, 12'h001, -1);
    checkOutput("t6_cnt_before", o_frame_cnt, 11);
    checkOutput("t6_sum_before", o_frame_sum, 24'h0000C0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_cnt", o_frame_cnt, 0);
    checkOutput("t6_async_sum", o_frame_sum, 0);
    checkOutput("t6_async_errs", {o_err_hlen, o_err_hsync, o_err_vlen, o_err_vsync}, 0);
    checkOutput("t6_async_flags", {o_locked, o_frame_done}, 0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
    applyStimulus(1'b1, 1'b1, 12'h123, 1'b0);
    applyStimulus(1'b1, 1'b1, 12'h123, 1'b0);
    checkOutput("t6_first_edge_no_done", o_frame_done, 0);
    checkOutput("t6_first_edge_cnt", o_frame_cnt, 0);
    driveLine(14, 0, 1'b1, 12'h123, -1);
    for (int l = 1; l < 10; l++) driveLine(16, 2, 1'b0, 12'h123, -1);
    applyStimulus(1'b1, 1'b1, 12'h123, 1'b0);
    applyStimulus(1'b1, 1'b1, 12'h123, 1'b0);
    checkOutput("t6_second_edge_done", o_frame_done, 1);
    checkOutput("t6_second_edge_cnt", o_frame_cnt, 1);
    checkOutput("t6_sum_rgb123", o_frame_sum, 24'h00B5E0);
    applyStimulus(1'b0, 1'b1, 12'h123, 1'b0);
    checkOutput("t6_done_one_cycle", o_frame_done, 0);
    checkOutput("t6_not_locked_yet", o_locked, 0);
    driveLine(13, 0, 1'b1, 12'h123, -1);
    for (int l = 1; l < 10; l++) driveLine(16, 2, 1'b0, 12'h123, -1);
    applyStimulus(1'b1, 1'b1, 12'h123, 1'b0);
    applyStimulus(1'b1, 1'b1, 12'h123, 1'b0);
    checkOutput("t6_locked", o_locked, 1);
    checkOutput("t6_cnt2", o_frame_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
